// File: rtl/toaplan2_pkg.sv
// Shared constants for the Toaplan2 GP9001 CPU bridge: operation codes,
// register byte offsets, FSM state encodings and the offset-to-operation decode.
package toaplan2_pkg;

    localparam logic [2:0] OP_NONE     = 3'd0;
    localparam logic [2:0] OP_SEL_REG  = 3'd1;
    localparam logic [2:0] OP_WR_REG   = 3'd2;
    localparam logic [2:0] OP_WR_RAM   = 3'd3;
    localparam logic [2:0] OP_RD_RAM_H = 3'd4;
    localparam logic [2:0] OP_RD_RAM_L = 3'd5;
    localparam logic [2:0] OP_SET_PTR  = 3'd6;

    // Byte offsets, i.e. {A[3:1], 1'b0}
    localparam logic [3:0] OFF_PTR     = 4'h0;
    localparam logic [3:0] OFF_RAM_H   = 4'h4;
    localparam logic [3:0] OFF_RAM_L   = 4'h6;
    localparam logic [3:0] OFF_REG_SEL = 4'h8;
    localparam logic [3:0] OFF_REG_DAT = 4'hC;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // OP_NONE marks an access completed immediately without a VDP handshake.
    function automatic logic [2:0] decode_op(input logic rw, input logic [3:0] off);
        logic [2:0] op;
        op = OP_NONE;
        if (rw) begin
            case (off)
                OFF_RAM_H: op = OP_RD_RAM_H;
                OFF_RAM_L: op = OP_RD_RAM_L;
                default:   op = OP_NONE;
            endcase
        end else begin
            case (off)
                OFF_PTR:     op = OP_SET_PTR;
                OFF_RAM_H:   op = OP_WR_RAM;
                OFF_RAM_L:   op = OP_WR_RAM;
                OFF_REG_SEL: op = OP_SEL_REG;
                OFF_REG_DAT: op = OP_WR_REG;
                default:     op = OP_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/toaplan2_wait_timer.sv
// Saturating count of cycles spent waiting for a VDP ACK; expired_o is combinational
// and asserts during the TIMEOUT-th waiting cycle. TIMEOUT = 0 never expires.
module toaplan2_wait_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && run_i && (cnt_q == LAST);

endmodule

// File: rtl/toaplan2_gp9001_bridge.sv
// 68k-to-GP9001 bridge: decodes CPU accesses into VDP operations and holds BUSY
// until the target VDP acknowledges, the wait times out, or the CPU aborts.
module toaplan2_gp9001_bridge
    import toaplan2_pkg::*;
#(
    parameter int NVDP    = 1,
    parameter int TIMEOUT = 256
) (
    input  logic                 CLK96,
    input  logic                 RESET96,
    input  logic [NVDP-1:0]      SEL,
    input  logic [2:0]           ADDR,
    input  logic                 RW,
    input  logic                 ASn,
    input  logic [15:0]          CPU_DIN,
    input  logic [NVDP-1:0]      VBL_STAT,
    input  logic [NVDP-1:0]      ACK,
    input  logic [16*NVDP-1:0]   VDP_DOUT,
    output logic                 BUSY,
    output logic [15:0]          RDATA,
    output logic [2:0]           OP,
    output logic [NVDP-1:0]      VSEL,
    output logic [15:0]          OP_DATA,
    output logic                 ERR
);

    logic [1:0]      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [NVDP-1:0] vsel_q, vsel_d;
    logic [15:0]     opdat_q, opdat_d;
    logic [15:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [NVDP-1:0] sel_oh;
    logic            sel_found;
    logic [15:0]     vdp_rd;
    logic [3:0]      offset;
    logic [2:0]      req_op;
    logic            start;
    logic            ack_tgt;
    logic            vbl_tgt;
    logic            op_is_read;
    logic            expired;

    // Lowest selected index wins if the decoder ever raises more than one SEL bit.
    always_comb begin
        sel_oh    = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NVDP; i++) begin
            if (SEL[i] && !sel_found) begin
                sel_oh[i] = 1'b1;
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        vdp_rd = '0;
        for (int i = 0; i < NVDP; i++) begin
            if (vsel_q[i]) begin
                vdp_rd = vdp_rd | VDP_DOUT[16*i +: 16];
            end
        end
    end

    assign offset     = {ADDR, 1'b0};
    assign req_op     = decode_op(RW, offset);
    assign start      = (state_q == ST_IDLE) && (|SEL) && !ASn;
    assign ack_tgt    = |(ACK & vsel_q);
    assign vbl_tgt    = |(VBL_STAT & sel_oh);
    assign op_is_read = (op_q == OP_RD_RAM_H) || (op_q == OP_RD_RAM_L);

    toaplan2_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk_i    (CLK96),
        .rst_i    (RESET96),
        .clr_i    (start && (req_op != OP_NONE)),
        .run_i    (state_q == ST_REQ),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        vsel_d  = vsel_q;
        opdat_d = opdat_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (req_op != OP_NONE) begin
                        state_d = ST_REQ;
                        op_d    = req_op;
                        vsel_d  = sel_oh;
                        opdat_d = CPU_DIN;
                    end else begin
                        state_d = ST_HOLD;
                        if (RW) begin
                            rdata_d = (offset == OFF_REG_DAT) ? {15'b0, ~vbl_tgt} : 16'h0000;
                        end
                    end
                end
            end
            ST_REQ: begin
                // ACK is checked first so it beats both an abort and a timeout on the same edge.
                if (ack_tgt) begin
                    if (op_is_read) begin
                        rdata_d = vdp_rd;
                    end
                    op_d    = OP_NONE;
                    vsel_d  = '0;
                    state_d = ST_HOLD;
                end else if (ASn) begin
                    op_d    = OP_NONE;
                    vsel_d  = '0;
                    state_d = ST_IDLE;
                end else if (expired) begin
                    rdata_d = 16'hFFFF;
                    err_d   = 1'b1;
                    op_d    = OP_NONE;
                    vsel_d  = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ASn) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                op_d    = OP_NONE;
                vsel_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NONE;
            vsel_q  <= '0;
            opdat_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            vsel_q  <= vsel_d;
            opdat_q <= opdat_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign BUSY    = (|SEL) && (state_q != ST_HOLD);
    assign RDATA   = rdata_q;
    assign OP      = op_q;
    assign VSEL    = vsel_q;
    assign OP_DATA = opdat_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_toaplan2_gp9001_bridge.sv
// Directed bench for the GP9001 bridge with two VDPs and an 8-cycle ACK timeout.
module tb_toaplan2_gp9001_bridge;

    logic        CLK96 = 1'b0;
    logic        RESET96;
    logic [1:0]  SEL;
    logic [2:0]  ADDR;
    logic        RW;
    logic        ASn;
    logic [15:0] CPU_DIN;
    logic [1:0]  VBL_STAT;
    logic [1:0]  ACK;
    logic [31:0] VDP_DOUT;
    logic        BUSY;
    logic [15:0] RDATA;
    logic [2:0]  OP;
    logic [1:0]  VSEL;
    logic [15:0] OP_DATA;
    logic        ERR;

    int n_chk  = 0;
    int n_pass = 0;

    toaplan2_gp9001_bridge #(
        .NVDP   (2),
        .TIMEOUT(8)
    ) dut (
        .CLK96   (CLK96),
        .RESET96 (RESET96),
        .SEL     (SEL),
        .ADDR    (ADDR),
        .RW      (RW),
        .ASn     (ASn),
        .CPU_DIN (CPU_DIN),
        .VBL_STAT(VBL_STAT),
        .ACK     (ACK),
        .VDP_DOUT(VDP_DOUT),
        .BUSY    (BUSY),
        .RDATA   (RDATA),
        .OP      (OP),
        .VSEL    (VSEL),
        .OP_DATA (OP_DATA),
        .ERR     (ERR)
    );

    always #5 CLK96 = ~CLK96;

    task automatic tick();
        @(posedge CLK96);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic release_bus();
        ASn = 1'b1;
        SEL = 2'b00;
        ACK = 2'b00;
        tick();
    endtask

    initial begin
        RESET96  = 1'b1;
        SEL      = 2'b00;
        ADDR     = 3'd0;
        RW       = 1'b1;
        ASn      = 1'b1;
        CPU_DIN  = 16'h0000;
        VBL_STAT = 2'b00;
        ACK      = 2'b00;
        VDP_DOUT = 32'h0;
        repeat (2) tick();
        chk("rst_op", OP, 0);
        chk("rst_vsel", VSEL, 0);
        chk("rst_opdata", OP_DATA, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_err", ERR, 0);
        chk("rst_busy", BUSY, 0);
        RESET96 = 1'b0;
        tick();

        // Write 1234 to VDP0 RAM (offset 4), ACK raised in the third REQ cycle
        SEL = 2'b01; ADDR = 3'd2; RW = 1'b0; CPU_DIN = 16'h1234; ASn = 1'b0;
        #1;
        chk("wr_busy_idle", BUSY, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("wr_op", OP, 3);
            chk("wr_opdata", OP_DATA, 16'h1234);
            chk("wr_vsel", VSEL, 2'b01);
            chk("wr_busy_req", BUSY, 1);
            if (i == 2) ACK = 2'b01;
            tick();
        end
        chk("wr_op_done", OP, 0);
        chk("wr_vsel_done", VSEL, 0);
        chk("wr_busy_hold", BUSY, 0);
        chk("wr_rdata_kept", RDATA, 16'h0000);
        ACK = 2'b00; ASn = 1'b1;
        tick();
        chk("wr_idle_busy", BUSY, 1);
        SEL = 2'b00;
        tick();

        // Read offset 6 from VDP1, stray ACK from VDP0 first
        SEL = 2'b10; ADDR = 3'd3; RW = 1'b1; ASn = 1'b0; VDP_DOUT = 32'hBEEF_1111;
        tick();
        chk("rdl_vsel", VSEL, 2'b10);
        chk("rdl_op", OP, 5);
        ACK = 2'b01;
        tick();
        chk("rdl_ignore_ack", OP, 5);
        ACK = 2'b10;
        tick();
        chk("rdl_rdata", RDATA, 16'hBEEF);
        chk("rdl_op_done", OP, 0);
        chk("rdl_busy", BUSY, 0);
        release_bus();

        // Two SEL bits high: VDP0 is the target
        SEL = 2'b11; ADDR = 3'd2; RW = 1'b1; ASn = 1'b0;
        tick();
        chk("prio_vsel", VSEL, 2'b01);
        chk("prio_op", OP, 4);
        ACK = 2'b01;
        tick();
        chk("prio_rdata", RDATA, 16'h1111);
        release_bus();

        // Status reads and an unmapped read complete immediately
        SEL = 2'b01; ADDR = 3'd6; RW = 1'b1; VBL_STAT = 2'b01; ASn = 1'b0;
        tick();
        chk("stat_busy", BUSY, 0);
        chk("stat_op", OP, 0);
        chk("stat_rdata_vbl", RDATA, 16'h0000);
        release_bus();
        VBL_STAT = 2'b00; SEL = 2'b01; ASn = 1'b0;
        tick();
        chk("stat_rdata_novbl", RDATA, 16'h0001);
        release_bus();
        ADDR = 3'd4; SEL = 2'b01; ASn = 1'b0;
        tick();
        chk("unmapped_rdata", RDATA, 16'h0000);
        chk("unmapped_busy", BUSY, 0);
        release_bus();

        // No ACK: eight REQ cycles, then timeout
        SEL = 2'b01; ADDR = 3'd4; RW = 1'b0; CPU_DIN = 16'h0042; ASn = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("to_op_held", OP, 1);
            chk("to_err_low", ERR, 0);
            tick();
        end
        chk("to_err", ERR, 1);
        chk("to_rdata", RDATA, 16'hFFFF);
        chk("to_op", OP, 0);
        chk("to_busy", BUSY, 0);
        tick();
        chk("to_err_pulse", ERR, 0);
        chk("to_hold", BUSY, 0);
        release_bus();

        // ACK on the same edge as expiry
        SEL = 2'b01; ADDR = 3'd2; RW = 1'b1; VDP_DOUT = 32'h0000_5A5A; ASn = 1'b0;
        tick();
        repeat (7) tick();
        chk("race_op", OP, 4);
        ACK = 2'b01;
        tick();
        chk("race_rdata", RDATA, 16'h5A5A);
        chk("race_err", ERR, 0);
        chk("race_busy", BUSY, 0);
        ACK = 2'b00;
        tick();
        chk("race_err_late", ERR, 0);
        release_bus();

        // CPU abandons the cycle mid-REQ
        SEL = 2'b01; ADDR = 3'd6; RW = 1'b0; CPU_DIN = 16'h7777; ASn = 1'b0;
        tick();
        tick();
        ASn = 1'b1;
        tick();
        chk("abort_op", OP, 0);
        chk("abort_vsel", VSEL, 0);
        chk("abort_err", ERR, 0);
        chk("abort_idle", BUSY, 1);
        SEL = 2'b00;
        repeat (10) tick();
        chk("abort_no_err", ERR, 0);

        // Reset asserted between clock edges during REQ
        SEL = 2'b01; ADDR = 3'd2; RW = 1'b0; CPU_DIN = 16'hCAFE; ASn = 1'b0;
        tick();
        chk("rr_op_before", OP, 3);
        #2 RESET96 = 1'b1;
        #1;
        chk("rr_op", OP, 0);
        chk("rr_vsel", VSEL, 0);
        chk("rr_opdata", OP_DATA, 0);
        chk("rr_rdata", RDATA, 0);
        chk("rr_err", ERR, 0);
        ASn = 1'b1; SEL = 2'b00;
        tick();
        RESET96 = 1'b0;
        tick();
        chk("rr_err_after", ERR, 0);
        SEL = 2'b01; ADDR = 3'd6; RW = 1'b0; CPU_DIN = 16'hABCD; ASn = 1'b0;
        tick();
        chk("post_op", OP, 2);
        chk("post_opdata", OP_DATA, 16'hABCD);
        chk("post_vsel", VSEL, 2'b01);
        ACK = 2'b01;
        tick();
        chk("post_op_done", OP, 0);
        chk("post_busy", BUSY, 0);
        chk("post_err", ERR, 0);
        release_bus();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/toaplan2_gp9001_bridge.md
TOAPLAN2_GP9001_BRIDGE -- requirements
Module: toaplan2_gp9001_bridge

Interface
REQ-001 The block SHALL take parameter NVDP, default 1, giving the number of GP9001 chips served (legal values 1 or 2).
REQ-002 The block SHALL take parameter TIMEOUT, default 256, giving the ACK wait limit in CLK96 cycles; the value 0 disables the timeout.
REQ-003 CLK96  in  1  sole clock, rising edge.
REQ-004 RESET96  in  1  reset; asynchronous, active-high.
REQ-005 SEL  in  NVDP  per-VDP select from the address decoder, registered, at most one bit high.
REQ-006 ADDR  in  3  CPU A[3:1], the register offset.
REQ-007 RW  in  1  1 = read, 0 = write.
REQ-008 ASn  in  1  68k address strobe, active-low.
REQ-009 CPU_DIN  in  16  CPU write data.
REQ-010 VBL_STAT  in  NVDP  per-VDP vblank status bit.
REQ-011 ACK  in  NVDP  per-VDP operation acknowledge.
REQ-012 VDP_DOUT  in  16*NVDP  per-VDP read data; VDP i occupies bits [16i+15:16i].
REQ-013 BUSY  out  1  wait request to the DTACK generator.
REQ-014 RDATA  out  16  read data returned to the CPU.
REQ-015 OP  out  3  encoded operation code.
REQ-016 VSEL  out  NVDP  one-hot target VDP for OP.
REQ-017 OP_DATA  out  16  write data accompanying OP.
REQ-018 ERR  out  1  one-cycle pulse on an ACK timeout.

Function
REQ-019 The decode from ADDR×2 SHALL be as follows.
- Writes: 0 = SET_PTR, 4 = WR_RAM, 6 = WR_RAM, 8 = SEL_REG, C = WR_REG.
- Reads: 4 = RD_RAM_H, 6 = RD_RAM_L.
- Read C = status: immediate, RDATA = {15'b0, ~VBL_STAT[target]}.
- All other offsets = immediate: reads return 16'h0000, writes are dropped.
REQ-020 The FSM SHALL have three states: IDLE, REQ and HOLD.
REQ-021 In IDLE with |SEL high and ASn low, an access that needs an ACK SHALL move the FSM to REQ on the next edge.
- OP, VSEL and OP_DATA (captured from CPU_DIN) are registered on that same edge.
REQ-022 In IDLE with |SEL high and ASn low, an immediate access SHALL move the FSM directly to HOLD on the next edge, with RDATA registered on that edge.
REQ-023 In REQ, ACK[target] high SHALL cause the following on the next edge.
- RDATA latched from the target VDP_DOUT slice (reads only; RDATA is unchanged on writes).
- OP returns to OP_NONE and VSEL returns to 0.
- The FSM moves to HOLD.
REQ-024 In HOLD, the FSM SHALL return to IDLE on the first edge with ASn high.
REQ-025 BUSY SHALL be combinational: (|SEL) AND (state ≠ HOLD).
- Every access therefore sees at least one busy cycle.
REQ-026 If TIMEOUT ≠ 0 and the FSM has spent TIMEOUT cycles in REQ without an ACK, the next edge SHALL do the following.
- RDATA = 16'hFFFF.
- ERR pulses for one cycle.
- OP is cleared.
- The FSM moves to HOLD.
REQ-027 The wait counter SHALL be $clog2(TIMEOUT+1) bits wide, SHALL clear on entry to REQ, and SHALL saturate (never wrap).
REQ-028 ASn going high while in REQ (an aborted cycle) SHALL clear OP and VSEL and return the FSM to IDLE on the next edge, with no ERR.
REQ-029 An ACK arriving on the same edge as a timeout expiry SHALL win: the VDP data is latched and ERR is not pulsed.
REQ-030 If more than one SEL bit is high, the lowest index SHALL be the target.
REQ-031 ACK from a non-target VDP, or ACK arriving outside REQ, SHALL be ignored.
REQ-032 OP, VSEL and OP_DATA SHALL remain stable throughout REQ.

Reset
REQ-033 While RESET96 is high, the block SHALL hold these values.
- state = IDLE.
- OP = OP_NONE, VSEL = 0, OP_DATA = 0.
- RDATA = 0, ERR = 0, counter = 0.
REQ-034 Reset asserted during REQ SHALL drop OP immediately (asynchronously), and no ERR SHALL follow.

Structure
REQ-035 A shared package toaplan2_pkg SHALL hold the following.
- The OP encodings: OP_NONE = 0, SEL_REG, WR_REG, WR_RAM, RD_RAM_H, RD_RAM_L, SET_PTR.
- The register offset constants.
REQ-036 The ACK timeout counter SHALL be a single sub-module, toaplan2_wait_timer, parametrised by TIMEOUT.

Verification
REQ-037 The bench SHALL cover these directed scenarios.
- Write 16'h1234 at ADDR×2 = 4 to VDP0, ACK after 3 cycles → OP = WR_RAM and OP_DATA = 1234 held for 3 cycles; BUSY falls the cycle after ACK is sampled; IDLE after ASn rises.
- NVDP = 2, read offset 6 to VDP1, VDP_DOUT[31:16] = 16'hBEEF → VSEL = 2'b10, OP = RD_RAM_L, RDATA = BEEF.
- Read offset C with VBL_STAT = 1 → HOLD one cycle after select with no OP issued; RDATA = 0000.
- TIMEOUT = 8, no ACK → ERR pulses once after 8 REQ cycles; RDATA = FFFF; the bus is released.
- ACK on the expiry edge → RDATA = VDP data, ERR stays 0; separately, ASn rising mid-REQ → OP cleared, IDLE, ERR stays 0.
- RESET96 pulsed mid-REQ → all outputs 0 asynchronously; the next access proceeds normally.
